// File: rtl/demux_1x8_rr_ctrl.sv
// rtl/demux_1x8_rr_ctrl.sv - round-robin burst scheduler for a 1-to-8 word demux
// One upstream stream is granted to one eligible channel at a time for up to BURST beats.
module demux_1x8_rr_ctrl #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [7:0]    chan_en,
  input  logic [7:0]    out_ready,
  output logic [7:0]    out_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    sel,
  output logic          busy,
  output logic          burst_done
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       burst_done_q, burst_done_d;

  logic [7:0] elig;
  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;
  logic       beat_xfer;

  // Search starts one past the previous grant, so the last winner is checked last.
  always_comb begin
    elig   = chan_en & out_ready;
    found  = 1'b0;
    winner = last_grant_q;
    idx    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_grant_q + 3'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    burst_done_d = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 8'd0;
    busy         = 1'b0;
    beat_xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && found) begin
          sel_d      = winner;
          beat_cnt_d = 8'd0;
          state_d    = XFER;
        end
      end
      XFER: begin
        busy      = 1'b1;
        out_valid = {7'd0, in_valid} << sel_q;
        in_ready  = out_ready[sel_q];
        beat_xfer = in_valid & out_ready[sel_q];
        if (beat_xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (in_last || (beat_cnt_q == LAST_BEAT)) begin
            last_grant_d = sel_q;
            burst_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 3'd0;
      last_grant_q <= 3'd7;
      beat_cnt_q   <= 8'd0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign sel        = sel_q;
  assign burst_done = burst_done_q;
  assign out_data   = in_data;

endmodule

// File: tb/tb_demux_1x8_rr_ctrl.sv
// tb/tb_demux_1x8_rr_ctrl.sv - directed bench for demux_1x8_rr_ctrl
// Per-cycle vector table plus hand sequences for rotation, early termination and reset.
module tb_demux_1x8_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] chan_en;
  logic [7:0] out_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;
  logic       burst_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux_1x8_rr_ctrl #(.DW(8), .BURST(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .chan_en(chan_en), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .busy(busy), .burst_done(burst_done)
  );

  typedef struct {
    logic       iv;
    logic       il;
    logic [7:0] en;
    logic [7:0] rdy;
    logic [2:0] sel;
    logic       busy;
    logic       bd;
    logic [7:0] ov;
    logic       ir;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(input logic iv, il, input logic [7:0] en, rdy,
                              input logic [2:0] s, input logic b, bd,
                              input logic [7:0] ov, input logic ir);
    vec_t v;
    v.iv = iv; v.il = il; v.en = en; v.rdy = rdy;
    v.sel = s; v.busy = b; v.bd = bd; v.ov = ov; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    chan_en = 8'hFF; out_ready = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_rr(input logic [7:0] en, input int n, input logic [2:0] seq [9], input string tag);
    int idle, beats, leak;
    do_reset();
    chan_en = en; in_valid = 1'b1; in_data = 8'hA0;
    @(negedge clk);
    for (int g = 0; g < n; g++) begin
      idle = 0;
      while (!busy && idle < 20) begin idle++; @(negedge clk); end
      chk($sformatf("%s_g%0d_idle", tag, g), idle, 1);
      chk($sformatf("%s_g%0d_sel", tag, g), 32'(sel), 32'(seq[g]));
      beats = 0; leak = 0;
      while (busy && beats < 20) begin
        if ((out_valid & ~en) != 8'd0) leak++;
        if (in_ready && out_valid == (8'd1 << sel)) beats++;
        @(negedge clk);
      end
      chk($sformatf("%s_g%0d_leak", tag, g), leak, 0);
      chk($sformatf("%s_g%0d_beats", tag, g), beats, 4);
      chk($sformatf("%s_g%0d_done", tag, g), 32'(burst_done), 1);
    end
  endtask

  initial begin
    logic [2:0] seq [9];

    //           iv il en     rdy    sel busy bd ov     ir
    tbl[0]  = mk(0, 0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 0);
    tbl[1]  = mk(1, 0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 0);
    tbl[2]  = mk(1, 0, 8'hFF, 8'hFF, 0, 1, 0, 8'h01, 1);
    tbl[3]  = mk(1, 0, 8'hFF, 8'hFF, 0, 1, 0, 8'h01, 1);
    tbl[4]  = mk(1, 0, 8'hFF, 8'hFE, 0, 1, 0, 8'h01, 0);
    tbl[5]  = mk(1, 0, 8'hFF, 8'hFE, 0, 1, 0, 8'h01, 0);
    tbl[6]  = mk(1, 0, 8'hFF, 8'hFF, 0, 1, 0, 8'h01, 1);
    tbl[7]  = mk(1, 0, 8'hFF, 8'hFF, 0, 1, 0, 8'h01, 1);
    tbl[8]  = mk(1, 0, 8'hFF, 8'hFF, 0, 0, 1, 8'h00, 0);
    tbl[9]  = mk(1, 0, 8'hFF, 8'hFF, 1, 1, 0, 8'h02, 1);
    tbl[10] = mk(1, 1, 8'hFF, 8'hFF, 1, 1, 0, 8'h02, 1);
    tbl[11] = mk(0, 1, 8'hFF, 8'hFF, 1, 0, 1, 8'h00, 0);
    tbl[12] = mk(1, 0, 8'hA5, 8'hFF, 1, 0, 0, 8'h00, 0);
    tbl[13] = mk(0, 0, 8'hA5, 8'hFF, 2, 1, 0, 8'h00, 1);
    tbl[14] = mk(1, 1, 8'h00, 8'hFF, 2, 1, 0, 8'h04, 1);
    tbl[15] = mk(1, 0, 8'hA5, 8'hFF, 2, 0, 1, 8'h00, 0);
    tbl[16] = mk(1, 1, 8'hA5, 8'hFF, 5, 1, 0, 8'h20, 1);
    tbl[17] = mk(1, 0, 8'hA5, 8'h7F, 5, 0, 1, 8'h00, 0);
    tbl[18] = mk(1, 1, 8'hA5, 8'hFF, 0, 1, 0, 8'h01, 1);
    tbl[19] = mk(1, 0, 8'h00, 8'hFF, 0, 0, 1, 8'h00, 0);
    tbl[20] = mk(1, 0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, 0);
    tbl[21] = mk(1, 0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, 0);
    tbl[22] = mk(1, 0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, 0);
    tbl[23] = mk(1, 0, 8'h00, 8'hFF, 0, 0, 0, 8'h00, 0);
    tbl[24] = mk(1, 0, 8'h40, 8'hFF, 0, 0, 0, 8'h00, 0);
    tbl[25] = mk(1, 1, 8'h40, 8'hFF, 6, 1, 0, 8'h40, 1);
    tbl[26] = mk(0, 0, 8'hFF, 8'hFF, 6, 0, 1, 8'h00, 0);

    do_reset();
    for (int i = 0; i < 27; i++) begin
      in_valid = tbl[i].iv; in_last = tbl[i].il;
      chan_en = tbl[i].en; out_ready = tbl[i].rdy;
      in_data = 8'h10 + 8'(i);
      @(negedge clk);
      chk($sformatf("v%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(burst_done), 32'(tbl[i].bd));
      chk($sformatf("v%0d_ovalid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_iready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(8'h10 + 8'(i)));
      @(posedge clk);
      #1;
    end

    for (int g = 0; g < 9; g++) seq[g] = 3'(g);
    run_rr(8'hFF, 9, seq, "rr_all");
    seq[0] = 3'd0; seq[1] = 3'd2; seq[2] = 3'd5; seq[3] = 3'd7; seq[4] = 3'd0;
    run_rr(8'hA5, 5, seq, "rr_a5");

    // Early termination on channel 3; enabling everything mid-burst must not disturb it.
    do_reset();
    chan_en = 8'h08; in_valid = 1'b1; in_data = 8'h30;
    @(posedge clk); #1 in_data = 8'h31;
    @(negedge clk);
    chk("et_sel", 32'(sel), 3);
    chk("et_beat1", 32'(out_valid), 32'h08);
    @(posedge clk); #1 in_data = 8'h32; in_last = 1'b1; chan_en = 8'hFF;
    @(negedge clk);
    chk("et_beat2", 32'(out_valid), 32'h08);
    chk("et_beat2_rdy", 32'(in_ready), 1);
    chk("et_beat2_data", 32'(out_data), 32'h32);
    @(posedge clk); #1 in_last = 1'b0;
    @(negedge clk);
    chk("et_done", 32'(burst_done), 1);
    chk("et_idle", 32'(busy), 0);
    @(negedge clk);
    chk("et_next_sel", 32'(sel), 4);
    chk("et_next_busy", 32'(busy), 1);

    // Reset after two beats to channel 4.
    do_reset();
    chan_en = 8'h10; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_sel", 32'(sel), 4);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; chan_en = 8'hFF;
    @(negedge clk);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_done", 32'(burst_done), 0);
    chk("rst_iready", 32'(in_ready), 0);
    @(negedge clk);
    chk("rst_regrant_sel", 32'(sel), 0);
    chk("rst_regrant_busy", 32'(busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
